// File: rtl/dcmp_pkg.sv
// Shared elaboration helpers for the pipelined N-input max comparator:
// tree sizing, latency and operand slicing.
package dcmp_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int lat(input int num_in);
    return clog2(num_in) + 1;
  endfunction

  // Number of surviving elements after l pairwise-max levels.
  function automatic int lvl_cnt(input int n, input int l);
    int c;
    c = n;
    for (int j = 0; j < l; j++) c = (c + 1) / 2;
    return c;
  endfunction

  // Flat node-array offset of level l+1 (sum of element counts of levels 1..l).
  function automatic int lvl_off(input int n, input int l);
    int s;
    s = 0;
    for (int j = 1; j <= l; j++) s += lvl_cnt(n, j);
    return s;
  endfunction

  function automatic int op_lsb(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/dcmp_max2.sv
// Combinational pairwise max with optional two's-complement compare.
// Equal operands return a_i, so the left element wins ties.
module dcmp_max2 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_mode_i,
  output logic [WIDTH-1:0] max_o
);

  logic b_wins;

  assign b_wins = signed_mode_i ? ($signed(b_i) > $signed(a_i)) : (b_i > a_i);
  assign max_o  = b_wins ? b_i : a_i;

endmodule

// File: rtl/multi_input_max_comparator_pipe.sv
// Pipelined N-input max comparator on a valid/ready stream with a global stall.
// Optional macro DCMP_INDEX_EN adds out_idx (lowest index among the tied winners).
module multi_input_max_comparator_pipe
  import dcmp_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_IN*WIDTH-1:0]          in_data,
  input  logic                             signed_mode,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_max,
  output logic [NUM_IN-1:0]                out_gt,
  output logic [clog2(NUM_IN+1)-1:0]       out_cnt
`ifdef DCMP_INDEX_EN
  ,
  output logic [(NUM_IN > 1 ? clog2(NUM_IN) : 1)-1:0] out_idx
`endif
);

  localparam int LVL  = clog2(NUM_IN);
  localparam int LVLA = (LVL > 0) ? LVL : 1;
  localparam int T    = lvl_off(NUM_IN, LVL);
  localparam int TA   = (T > 0) ? T : 1;
  localparam int SMA  = (LVL > 1) ? LVL - 1 : 1;
  localparam int CW   = clog2(NUM_IN + 1);
  localparam int IW   = (NUM_IN > 1) ? clog2(NUM_IN) : 1;

  logic                    adv;
  logic [LVLA-1:0]         vld_q;
  logic [NUM_IN*WIDTH-1:0] ops_q  [LVLA];
  logic                    sm_q   [SMA];
  logic [WIDTH-1:0]        node_q [TA];
  logic [WIDTH-1:0]        max_w  [TA];

  logic                    fin_vld;
  logic [WIDTH-1:0]        fin_max;
  logic [NUM_IN*WIDTH-1:0] fin_ops;

  logic                    out_vld_q;
  logic [WIDTH-1:0]        out_max_q;
  logic [NUM_IN-1:0]       out_gt_q, gt_d;
  logic [CW-1:0]           out_cnt_q, cnt_d;

  assign adv      = ~out_vld_q | out_ready;
  assign in_ready = adv;

  // Level l reduces lvl_cnt(l-1) elements into lvl_cnt(l) nodes stored at node_q[CO +: NC].
  for (genvar l = 1; l <= LVL; l++) begin : g_lvl
    localparam int NP = lvl_cnt(NUM_IN, l - 1);
    localparam int NC = lvl_cnt(NUM_IN, l);
    localparam int CO = lvl_off(NUM_IN, l - 1);
    logic lvl_sm;

    if (l == 1) begin : g_sm_in
      assign lvl_sm = signed_mode;
    end else begin : g_sm_q
      assign lvl_sm = sm_q[l-2];
    end

    for (genvar k = 0; k < NC; k++) begin : g_node
      if (2 * k + 1 < NP) begin : g_pair
        logic [WIDTH-1:0] a, b;
        if (l == 1) begin : g_src_in
          assign a = in_data[op_lsb(2*k, WIDTH) +: WIDTH];
          assign b = in_data[op_lsb(2*k+1, WIDTH) +: WIDTH];
        end else begin : g_src_q
          assign a = node_q[lvl_off(NUM_IN, l-2) + 2*k];
          assign b = node_q[lvl_off(NUM_IN, l-2) + 2*k + 1];
        end
        dcmp_max2 #(.WIDTH(WIDTH)) u_max2 (
          .a_i          (a),
          .b_i          (b),
          .signed_mode_i(lvl_sm),
          .max_o        (max_w[CO+k])
        );
      end else begin : g_pass
        if (l == 1) begin : g_src_in
          assign max_w[CO+k] = in_data[op_lsb(2*k, WIDTH) +: WIDTH];
        end else begin : g_src_q
          assign max_w[CO+k] = node_q[lvl_off(NUM_IN, l-2) + 2*k];
        end
      end
    end
  end

  if (LVL == 0) begin : g_fin_direct
    assign max_w[0] = '0;
    assign fin_vld  = in_valid;
    assign fin_max  = in_data[WIDTH-1:0];
    assign fin_ops  = in_data;
  end else begin : g_fin_tree
    assign fin_vld = vld_q[LVL-1];
    assign fin_max = node_q[T-1];
    assign fin_ops = ops_q[LVL-1];
  end

  // Equality against the winner; the raw compare is sign-agnostic.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    gt_d  = '0;
    cnt_d = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (fin_ops[op_lsb(i, WIDTH) +: WIDTH] == fin_max) begin
        gt_d[i] = 1'b1;
        cnt_d   = cnt_d + CW'(1);
      end
    end
  end

`ifdef DCMP_INDEX_EN
  logic [IW-1:0] idx_d, out_idx_q;

  always_comb begin
    idx_d = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (gt_d[i]) idx_d = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_idx_q <= '0;
    else if (adv) out_idx_q <= idx_d;
  end

  assign out_idx = out_idx_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (!rst_n) begin
      vld_q     <= '0;
      out_vld_q <= 1'b0;
      out_max_q <= '0;
      out_gt_q  <= '0;
      out_cnt_q <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int j = 1; j < LVLA; j++) vld_q[j] <= vld_q[j-1];
      out_vld_q <= fin_vld;
      out_max_q <= fin_max;
      out_gt_q  <= gt_d;
      out_cnt_q <= cnt_d;
    end
  end

  // NOTE: payload registers are not reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int t = 0; t < TA; t++) node_q[t] <= max_w[t];
      ops_q[0] <= in_data;
      for (int j = 1; j < LVLA; j++) ops_q[j] <= ops_q[j-1];
      sm_q[0] <= signed_mode;
      for (int j = 1; j < SMA; j++) sm_q[j] <= sm_q[j-1];
    end
  end

  assign out_valid = out_vld_q;
  assign out_max   = out_max_q;
  assign out_gt    = out_gt_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_multi_input_max_comparator_pipe.sv
// Self-checking bench: scoreboard on a 4x4 instance plus directed checks
// on 5x8 and 1x4 instances. Honours DCMP_INDEX_EN when defined.
module tb_multi_input_max_comparator_pipe;
  import dcmp_pkg::*;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int LAT = lat(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [15:0]   in_data;
  logic [3:0]    out_max, out_gt;
  logic [2:0]    out_cnt;
`ifdef DCMP_INDEX_EN
  logic [1:0]    out_idx;
  logic [2:0]    p5_idx;
  logic          p1_idx;
`endif

  logic          p5_in_valid, p5_in_ready, p5_sm, p5_out_valid;
  logic [39:0]   p5_in_data;
  logic [7:0]    p5_max;
  logic [4:0]    p5_gt;
  logic [2:0]    p5_cnt;

  logic          p1_in_valid, p1_in_ready, p1_out_valid, p1_gt, p1_cnt;
  logic [3:0]    p1_in_data, p1_max;

  multi_input_max_comparator_pipe #(.NUM_IN(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_max(out_max), .out_gt(out_gt), .out_cnt(out_cnt)
`ifdef DCMP_INDEX_EN
    , .out_idx(out_idx)
`endif
  );

  multi_input_max_comparator_pipe #(.NUM_IN(5), .WIDTH(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(p5_in_valid), .in_ready(p5_in_ready),
    .in_data(p5_in_data), .signed_mode(p5_sm), .out_valid(p5_out_valid),
    .out_ready(1'b1), .out_max(p5_max), .out_gt(p5_gt), .out_cnt(p5_cnt)
`ifdef DCMP_INDEX_EN
    , .out_idx(p5_idx)
`endif
  );

  multi_input_max_comparator_pipe #(.NUM_IN(1), .WIDTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(p1_in_valid), .in_ready(p1_in_ready),
    .in_data(p1_in_data), .signed_mode(1'b0), .out_valid(p1_out_valid),
    .out_ready(1'b1), .out_max(p1_max), .out_gt(p1_gt), .out_cnt(p1_cnt)
`ifdef DCMP_INDEX_EN
    , .out_idx(p1_idx)
`endif
  );

  typedef struct {
    logic [3:0] mx;
    logic [3:0] gt;
    logic [2:0] cnt;
    logic [1:0] idx;
    int         cyc;
    bit         lat_chk;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_out = 0;
  bit   lat_chk_en = 1'b0;
  bit   prev_stall = 1'b0;
  logic [3:0] h_max, h_gt;
  logic [2:0] h_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] d, input logic sm);
    exp_t       e;
    logic [3:0] best, v;
    best = d[3:0];
    for (int i = 1; i < N; i++) begin
      v = d[i*4 +: 4];
      if (sm ? ($signed(v) > $signed(best)) : (v > best)) best = v;
    end
    e.mx = best; e.gt = '0; e.cnt = '0; e.idx = '0; e.cyc = 0; e.lat_chk = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (d[i*4 +: 4] == best) begin
        e.gt[i] = 1'b1;
        e.cnt   = e.cnt + 3'd1;
        e.idx   = 2'(i);
      end
    end
    return e;
  endfunction

  function automatic logic [15:0] pack(input logic [3:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: pop on output handshake, push on input handshake, check stall behaviour.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", out_valid, 1);
        check("hold_max", out_max, h_max);
        check("hold_gt", out_gt, h_gt);
        check("hold_cnt", out_cnt, h_cnt);
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        prev_stall = 1'b1;
        h_max = out_max; h_gt = out_gt; h_cnt = out_cnt;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("spurious_out", 32'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          check("max", out_max, e.mx);
          check("gt", out_gt, e.gt);
          check("cnt", out_cnt, e.cnt);
`ifdef DCMP_INDEX_EN
          check("idx", out_idx, e.idx);
`endif
          if (e.lat_chk) check("latency", cyc - e.cyc, LAT);
        end
      end
      if (in_valid && in_ready) begin
        e = model(in_data, signed_mode);
        e.cyc = cyc;
        e.lat_chk = lat_chk_en;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic sm);
    int n;
    bit acc;
    n = 0; acc = 1'b0;
    in_valid = 1'b1; in_data = d; signed_mode = sm;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", in_ready, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(sb.size()), 0);
  endtask

  task automatic p5_run(input logic [39:0] d, input logic sm, input logic [7:0] emax,
                        input logic [4:0] egt, input logic [2:0] ecnt, input logic [2:0] eidx);
    int n;
    p5_in_data = d; p5_sm = sm; p5_in_valid = 1'b1;
    @(posedge clk);
    #1;
    p5_in_valid = 1'b0;
    n = 1;
    while (!p5_out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("p5_latency", n, 4);
    check("p5_max", p5_max, emax);
    check("p5_gt", p5_gt, egt);
    check("p5_cnt", p5_cnt, ecnt);
`ifdef DCMP_INDEX_EN
    check("p5_idx", p5_idx, eidx);
`else
    if (eidx > 3'd4) check("p5_idx_arg", eidx, 0);
`endif
  endtask

  initial begin
    int n, n0;
    in_valid = 1'b0; in_data = '0; signed_mode = 1'b0; out_ready = 1'b1;
    p5_in_valid = 1'b0; p5_in_data = '0; p5_sm = 1'b0;
    p1_in_valid = 1'b0; p1_in_data = '0;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_max", out_max, 0);
    check("rst_out_gt", out_gt, 0);
    check("rst_out_cnt", out_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_rst", in_ready, 1);

    // Basic, ties, all-equal, signed vs unsigned of the same vector.
    lat_chk_en = 1'b1;
    send(pack(4'd9, 4'd3, 4'd5, 4'd2), 1'b0);
    send(pack(4'd7, 4'd7, 4'd1, 4'd7), 1'b0);
    send(pack(4'd8, 4'd8, 4'd8, 4'd8), 1'b0);
    send(pack(4'hF, 4'h2, 4'h8, 4'h0), 1'b1);
    send(pack(4'hF, 4'h2, 4'h8, 4'h0), 1'b0);
    drain();
    lat_chk_en = 1'b0;

    // Backpressure: 6 back-to-back vectors, downstream stalls for cycles 4..6.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(pack(4'(i), 4'(i + 3), 4'(9 - i), 4'(2 * i)), 1'(i % 2));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out - n0, 6);

    // Random operands, random signed mode and random downstream readiness.
    fork
      begin
        for (int i = 0; i < 30; i++)
          send(16'($urandom), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two vectors in flight: both must vanish.
    lat_chk_en = 1'b1;
    send(pack(4'd1, 4'd2, 4'd3, 4'd4), 1'b0);
    send(pack(4'd5, 4'd6, 4'd7, 4'd8), 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_max", out_max, 0);
    check("mid_rst_gt", out_gt, 0);
    check("mid_rst_cnt", out_cnt, 0);
    check("mid_rst_ready", in_ready, 1);
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(pack(4'd3, 4'hC, 4'hC, 4'd0), 1'b0);
    in_valid = 1'b0;
    drain();
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("no_ghost_out", out_valid, 0);
    lat_chk_en = 1'b0;

    // 5 x 8-bit instance: unsigned ties and signed 7F vs 80.
    p5_run({8'd7, 8'd200, 8'd3, 8'd200, 8'd10}, 1'b0, 8'd200, 5'b01010, 3'd2, 3'd1);
    p5_run({8'hFF, 8'h80, 8'h01, 8'h7F, 8'h80}, 1'b1, 8'h7F, 5'b00010, 3'd1, 3'd1);
    @(posedge clk);
    #1;

    // Single-operand instance: one register stage.
    p1_in_data = 4'hA; p1_in_valid = 1'b1;
    @(posedge clk);
    #1;
    p1_in_valid = 1'b0;
    n = 1;
    while (!p1_out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("p1_latency", n, 1);
    check("p1_max", p1_max, 4'hA);
    check("p1_gt", p1_gt, 1);
    check("p1_cnt", p1_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

endmodule
